fft_bitrev_reorder: RTL and testbench

// Output-side companion of the SDF FFT pipeline. The FFT emits each N-point frame in
// bit-reversed bin order. This block buffers the frame in a ping-pong RAM and replays
// it in natural order (bin 0..N-1) with a bin index and an end-of-frame marker.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/reorder_ram.sv | 54 +++++
 rtl/fft_bitrev_reorder.sv | 150 +++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
//------------------------------------------------------------------------------
// Module   : fft_pkg
// Brief    : Shared types and the bit-reversal helper for the FFT output reorder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

    localparam int DEFAULT_N     = 32;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Reverses the low 'bits' bits of value; upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int bits);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < bits; i++) begin
            result[i] = value[bits-1-i];
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reorder_ram.sv
//------------------------------------------------------------------------------
// Module   : reorder_ram
// Brief    : Simple dual-port RAM, one write port, one registered read port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reorder_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
//------------------------------------------------------------------------------
// Module   : fft_bitrev_reorder
// Brief    : Buffers bit-reversed FFT frames in a ping-pong RAM, replays them in
//            natural bin order with index and end-of-frame marker.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int LOG2N = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             enable_out,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    logic [LOG2N-1:0] wr_cnt_q,  wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       bank_full_q, bank_full_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] rd_cnt_q,  rd_cnt_d;
    logic             enable_out_q, enable_out_d;
    logic [LOG2N-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;

    logic             w_rd_en;
    logic [LOG2N-1:0] w_wr_idx_rev;
    logic [LOG2N:0]   w_wr_addr;
    logic [LOG2N:0]   w_rd_addr;
    logic [2*WIDTH-1:0] w_rd_data;

    assign w_rd_en      = (rd_state_q == RD_READ);
    assign w_wr_idx_rev = LOG2N'(bitrev(32'(wr_cnt_q), LOG2N));
    assign w_wr_addr    = {wr_bank_q, w_wr_idx_rev};
    assign w_rd_addr    = {rd_bank_q, rd_cnt_q};

    reorder_ram #(
        .ADDR_W (LOG2N + 1),
        .DATA_W (2 * WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (enable_in),
        .wr_addr (w_wr_addr),
        .wr_data ({in_re, in_im}),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        wr_bank_d    = wr_bank_q;
        bank_full_d  = bank_full_q;
        rd_state_d   = rd_state_q;
        rd_bank_d    = rd_bank_q;
        rd_cnt_d     = rd_cnt_q;

        case (rd_state_q)
            RD_IDLE: begin
                if (bank_full_q[0]) begin
                    rd_state_d = RD_READ;
                    rd_bank_d  = 1'b0;
                    rd_cnt_d   = '0;
                end else if (bank_full_q[1]) begin
                    rd_state_d = RD_READ;
                    rd_bank_d  = 1'b1;
                    rd_cnt_d   = '0;
                end
            end
            RD_READ: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    bank_full_d[rd_bank_q] = 1'b0;
                    if (bank_full_q[~rd_bank_q]) begin
                        rd_bank_d = ~rd_bank_q;
                        rd_cnt_d  = '0;
                    end else begin
                        rd_state_d = RD_IDLE;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        // Write side evaluated after the read side so a completing writer's set wins.
        if (enable_in) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST_IDX) begin
                wr_cnt_d               = '0;
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
            end
        end
    end

    // Metadata is aligned with the RAM's registered read data.
    always_comb begin
        enable_out_d = w_rd_en;
        out_idx_d    = w_rd_en ? rd_cnt_q : out_idx_q;
        out_last_d   = w_rd_en && (rd_cnt_q == LAST_IDX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            bank_full_q  <= 2'b00;
            rd_state_q   <= RD_IDLE;
            rd_bank_q    <= 1'b0;
            rd_cnt_q     <= '0;
            enable_out_q <= 1'b0;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            wr_bank_q    <= wr_bank_d;
            bank_full_q  <= bank_full_d;
            rd_state_q   <= rd_state_d;
            rd_bank_q    <= rd_bank_d;
            rd_cnt_q     <= rd_cnt_d;
            enable_out_q <= enable_out_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
        end
    end

    assign enable_out = enable_out_q;
    assign out_re     = w_rd_data[2*WIDTH-1:WIDTH];
    assign out_im     = w_rd_data[WIDTH-1:0];
    assign out_idx    = out_idx_q;
    assign out_last   = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
//------------------------------------------------------------------------------
// Module   : tb_fft_bitrev_reorder
// Brief    : Directed self-checking bench for the bit-reversal reorder buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fft_bitrev_reorder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable_in = 1'b0;
    logic [7:0] in_re = '0;
    logic [7:0] in_im = '0;
    logic       enable_out;
    logic [7:0] out_re;
    logic [7:0] out_im;
    logic [4:0] out_idx;
    logic       out_last;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    int last_in_edge = 0;

    logic [7:0] q_re[$];
    logic [7:0] q_im[$];
    int         q_idx[$];
    int         q_cyc[$];
    logic       q_last[$];

    fft_bitrev_reorder #(.N(32), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_in  (enable_in),
        .in_re      (in_re),
        .in_im      (in_im),
        .enable_out (enable_out),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_idx    (out_idx),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Capture every valid output sample with the edge number that produced it.
    always @(negedge clk) begin
        if (enable_out === 1'b1) begin
            q_re.push_back(out_re);
            q_im.push_back(out_im);
            q_idx.push_back(int'(out_idx));
            q_cyc.push_back(edge_n);
            q_last.push_back(out_last);
        end
    end

    function automatic int brev5(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 5; i++) begin
            if (((v >> i) & 1) == 1) r = r | (1 << (4 - i));
        end
        return r;
    endfunction

    // {re, im} carried by natural bin 'bin' for each stimulus pattern.
    function automatic logic [15:0] pat_val(input int pat, input int bin);
        logic [7:0] re;
        logic [7:0] im;
        case (pat)
            0: begin re = 8'(bin);       im = 8'(0 - bin);   end
            1: begin re = 8'(100 + bin); im = 8'(3 * bin);   end
            default: begin
                re = (bin % 2 == 1) ? 8'h7F : 8'h80;
                im = (bin % 2 == 1) ? 8'h80 : 8'h7F;
            end
        endcase
        return {re, im};
    endfunction

    task automatic flush_queues();
        q_re.delete(); q_im.delete(); q_idx.delete(); q_cyc.delete(); q_last.delete();
    endtask

    task automatic send_frame(input int pat, input bit gapped, input int nsamp);
        logic [15:0] v;
        for (int j = 0; j < nsamp; j++) begin
            v = pat_val(pat, brev5(j));
            in_re = v[15:8];
            in_im = v[7:0];
            enable_in = 1'b1;
            @(posedge clk); #1;
            last_in_edge = edge_n;
            if (gapped) begin
                enable_in = 1'b0;
                @(posedge clk); #1;
            end
        end
        enable_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (enable_out !== 1'b0 || out_last !== 1'b0)
            $display("FAIL reset_ctrl: enable_out=%b out_last=%b required 0/0", enable_out, out_last);
        checks++;
        if (out_re !== 8'h00 || out_im !== 8'h00 || out_idx !== 5'd0)
            $display("FAIL reset_data: re=%h im=%h idx=%0d required 00/00/0", out_re, out_im, out_idx);
        if (enable_out !== 1'b0 || out_last !== 1'b0) failures++;
        else if (out_re !== 8'h00 || out_im !== 8'h00 || out_idx !== 5'd0) failures++;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (enable_out !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: enable_out=%b required 0", enable_out);
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] e;
        flush_queues();
        send_frame(0, 1'b0, 32);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (q_re.size() != 32) begin
            failures++;
            $display("FAIL single_count: got %0d samples required 32", q_re.size());
        end
        for (int k = 0; k < 32 && k < q_re.size(); k++) begin
            e = pat_val(0, k);
            checks++;
            if ({q_re[k], q_im[k]} !== e) begin
                failures++;
                $display("FAIL single_data[%0d]: got %h/%h required %h/%h", k, q_re[k], q_im[k], e[15:8], e[7:0]);
            end
            checks++;
            if (q_idx[k] != k || q_last[k] !== (k == 31) || q_cyc[k] != last_in_edge + 2 + k) begin
                failures++;
                $display("FAIL single_meta[%0d]: idx=%0d last=%b edge=%0d required %0d/%b/%0d",
                         k, q_idx[k], q_last[k], q_cyc[k], k, (k == 31), last_in_edge + 2 + k);
            end
        end
        checks++;
        if (enable_out !== 1'b0 || out_last !== 1'b0 || out_idx !== 5'd31 || out_re !== 8'd31) begin
            failures++;
            $display("FAIL single_hold: en=%b last=%b idx=%0d re=%0d required 0/0/31/31",
                     enable_out, out_last, out_idx, out_re);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        int first_last;
        int bin;
        flush_queues();
        send_frame(0, 1'b0, 32);
        first_last = last_in_edge;
        send_frame(1, 1'b0, 32);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (q_re.size() != 64) begin
            failures++;
            $display("FAIL b2b_count: got %0d samples required 64", q_re.size());
        end
        for (int k = 0; k < 64 && k < q_re.size(); k++) begin
            bin = k % 32;
            e = pat_val((k < 32) ? 0 : 1, bin);
            checks++;
            if ({q_re[k], q_im[k]} !== e) begin
                failures++;
                $display("FAIL b2b_data[%0d]: got %h/%h required %h/%h", k, q_re[k], q_im[k], e[15:8], e[7:0]);
            end
            checks++;
            if (q_idx[k] != bin || q_last[k] !== (bin == 31) || q_cyc[k] != first_last + 2 + k) begin
                failures++;
                $display("FAIL b2b_meta[%0d]: idx=%0d last=%b edge=%0d required %0d/%b/%0d",
                         k, q_idx[k], q_last[k], q_cyc[k], bin, (bin == 31), first_last + 2 + k);
            end
        end
    endtask

    task automatic test_gapped();
        logic [15:0] e;
        flush_queues();
        send_frame(0, 1'b1, 32);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (q_re.size() != 32) begin
            failures++;
            $display("FAIL gapped_count: got %0d samples required 32", q_re.size());
        end
        for (int k = 0; k < 32 && k < q_re.size(); k++) begin
            e = pat_val(0, k);
            checks++;
            if ({q_re[k], q_im[k]} !== e || q_idx[k] != k || q_last[k] !== (k == 31)
                || q_cyc[k] != last_in_edge + 2 + k) begin
                failures++;
                $display("FAIL gapped[%0d]: got %h/%h idx=%0d edge=%0d required %h/%h idx=%0d edge=%0d",
                         k, q_re[k], q_im[k], q_idx[k], q_cyc[k], e[15:8], e[7:0], k, last_in_edge + 2 + k);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] e;
        flush_queues();
        send_frame(1, 1'b0, 10);
        rst = 1'b1;
        #1;
        checks++;
        if (enable_out !== 1'b0 || out_re !== 8'h00 || out_im !== 8'h00 || out_idx !== 5'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: en=%b re=%h im=%h idx=%0d last=%b required all 0",
                     enable_out, out_re, out_im, out_idx, out_last);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(1, 1'b0, 32);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (q_re.size() != 32) begin
            failures++;
            $display("FAIL midreset_count: got %0d samples required 32", q_re.size());
        end
        for (int k = 0; k < 32 && k < q_re.size(); k++) begin
            e = pat_val(1, k);
            checks++;
            if ({q_re[k], q_im[k]} !== e || q_idx[k] != k || q_last[k] !== (k == 31)
                || q_cyc[k] != last_in_edge + 2 + k) begin
                failures++;
                $display("FAIL midreset[%0d]: got %h/%h idx=%0d edge=%0d required %h/%h idx=%0d edge=%0d",
                         k, q_re[k], q_im[k], q_idx[k], q_cyc[k], e[15:8], e[7:0], k, last_in_edge + 2 + k);
            end
        end
    endtask

    task automatic test_reset_during_burst();
        bit found;
        flush_queues();
        send_frame(0, 1'b0, 32);
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (enable_out === 1'b1 && out_idx === 5'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL burst_idx5_timeout: idx 5 seen=%b required 1", found);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (enable_out !== 1'b0 || out_re !== 8'h00 || out_idx !== 5'd0) begin
            failures++;
            $display("FAIL burst_async_reset: en=%b re=%h idx=%0d required 0/00/0", enable_out, out_re, out_idx);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        flush_queues();
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (q_re.size() != 0) begin
            failures++;
            $display("FAIL burst_no_output: got %0d samples after reset required 0", q_re.size());
        end
    endtask

    task automatic test_extremes();
        logic [15:0] e;
        flush_queues();
        send_frame(2, 1'b0, 32);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (q_re.size() != 32) begin
            failures++;
            $display("FAIL extremes_count: got %0d samples required 32", q_re.size());
        end
        for (int k = 0; k < 32 && k < q_re.size(); k++) begin
            e = pat_val(2, k);
            checks++;
            if ({q_re[k], q_im[k]} !== e || q_idx[k] != k || q_last[k] !== (k == 31)) begin
                failures++;
                $display("FAIL extremes[%0d]: got %h/%h idx=%0d last=%b required %h/%h idx=%0d last=%b",
                         k, q_re[k], q_im[k], q_idx[k], q_last[k], e[15:8], e[7:0], k, (k == 31));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gapped();
        test_reset_mid_frame();
        test_reset_during_burst();
        test_extremes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
